// File: rtl/ipf_pass_sequencer.sv
// ipf_pass_sequencer
// Runs the image pre-filter engine once for every mode selected in
// mode_mask (0 = gradient, 1 = sharpen, 2 = smooth), lowest mode first.
// For each pass it holds the engine in reset, launches it, forwards its
// output writes to the result bank of that mode, counts them, and checks
// the count once the engine has finished.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           job request (sampled in IDLE only)
//   mode_mask[2:0]  modes to run, sampled with start
//   busy            job in progress
//   done            one-cycle pulse at job end
//   error           some pass failed (held until the next accepted start)
//   pass_err[2:0]   per-mode failure flags
//   ipf_rst         engine reset (registered)
//   ipf_mode        engine mode select
//   ipf_gray_ready  engine launch pulse
//   ipf_finish      engine finished (level)
//   ipf_valid/addr/data  engine write port
//   wr_en/bank/addr/data result-bank write port (one cycle after ipf_valid)
module ipf_pass_sequencer #(
   parameter int ADDR_WIDTH   = 16,
   parameter int OUT_WIDTH    = 9,
   parameter int EXP_WRITES   = 64516,
   parameter int TO_WIDTH     = 20,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            mode_mask,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            pass_err,
   output logic                  ipf_rst,
   output logic [1:0]            ipf_mode,
   output logic                  ipf_gray_ready,
   input  logic                  ipf_finish,
   input  logic                  ipf_valid,
   input  logic [ADDR_WIDTH-1:0] ipf_addr,
   input  logic [OUT_WIDTH-1:0]  ipf_data,
   output logic                  wr_en,
   output logic [1:0]            wr_bank,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [OUT_WIDTH-1:0]  wr_data
);

   localparam int          PH_W  = $clog2(DRAIN_CYCLES + 2) + 1;
   localparam logic [16:0] EXP_W = 17'(EXP_WRITES);

   typedef enum logic [2:0] {
      IDLE, SELECT, CLEAR, LAUNCH, RUN, DRAIN, CHECK, DONE
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [2:0]          pend;
   logic [16:0]         wr_cnt;
   logic [TO_WIDTH-1:0] to_cnt;
   logic [PH_W-1:0]     phase_cnt;
   logic [1:0]          sel_mode;
   logic [2:0]          sel_bit;
   logic [2:0]          mode_bit;
   logic                timeout_hit;
   logic                accept;
   logic                busy_n;
   logic                done_n;
   logic                ipf_rst_n;
   logic                gray_ready_n;

   // Lowest pending mode, and the flag bit of the mode currently running
   always_comb begin
      sel_mode = 2'd0;
      sel_bit  = 3'b001;
      if (pend[0]) begin
         sel_mode = 2'd0;
         sel_bit  = 3'b001;
      end else if (pend[1]) begin
         sel_mode = 2'd1;
         sel_bit  = 3'b010;
      end else begin
         sel_mode = 2'd2;
         sel_bit  = 3'b100;
      end
      mode_bit = 3'b001 << ipf_mode;
   end

   // Finish wins over timeout. A write arriving in the timeout cycle is
   // dropped, so no forwarded write can land on the done pulse.
   assign timeout_hit = (state == RUN) && !ipf_finish && (&to_cnt);
   assign accept      = ipf_valid &&
                        (((state == RUN) && !timeout_hit) || (state == DRAIN));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SELECT; else next_state = IDLE;
         SELECT:  if (pend == 3'b000) next_state = DONE; else next_state = CLEAR;
         CLEAR:   if (phase_cnt == PH_W'(1)) next_state = LAUNCH; else next_state = CLEAR;
         LAUNCH:  next_state = RUN;
         RUN: begin
            if (ipf_finish)       next_state = DRAIN;
            else if (&to_cnt)     next_state = DONE;
            else                  next_state = RUN;
         end
         DRAIN:   if (phase_cnt == PH_W'(DRAIN_CYCLES - 1)) next_state = CHECK;
                  else next_state = DRAIN;
         CHECK:   next_state = SELECT;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Control outputs decoded from the next state so the registered copies
   // line up with the state they describe
   always_comb begin
      busy_n       = (next_state != IDLE) && (next_state != DONE);
      done_n       = (next_state == DONE);
      ipf_rst_n    = !((next_state == LAUNCH) || (next_state == RUN) ||
                       (next_state == DRAIN));
      gray_ready_n = (next_state == LAUNCH);
   end

   // Registered control outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         ipf_rst        <= 1'b1;
         ipf_gray_ready <= 1'b0;
      end else begin
         busy           <= busy_n;
         done           <= done_n;
         ipf_rst        <= ipf_rst_n;
         ipf_gray_ready <= gray_ready_n;
      end
   end

   // Pass bookkeeping: pending modes, current mode, counters, error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      <= 3'b000;
         ipf_mode  <= 2'd0;
         wr_cnt    <= 17'd0;
         to_cnt    <= '0;
         phase_cnt <= '0;
         error     <= 1'b0;
         pass_err  <= 3'b000;
      end else begin
         // phase_cnt times CLEAR and DRAIN; restarts on every state change
         if (next_state != state) begin
            phase_cnt <= '0;
         end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
         end

         if (accept && (wr_cnt != 17'h1FFFF)) begin
            wr_cnt <= wr_cnt + 17'd1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  pend     <= mode_mask;
                  error    <= 1'b0;
                  pass_err <= 3'b000;
               end
            end
            SELECT: begin
               if (pend != 3'b000) begin
                  pend     <= pend & ~sel_bit;
                  ipf_mode <= sel_mode;
               end
               wr_cnt <= 17'd0;
               to_cnt <= '0;
            end
            RUN: begin
               to_cnt <= to_cnt + TO_WIDTH'(1);
               if (timeout_hit) begin
                  pass_err <= pass_err | mode_bit;
                  error    <= 1'b1;
                  pend     <= 3'b000;
               end
            end
            CHECK: begin
               if (wr_cnt != EXP_W) begin
                  pass_err <= pass_err | mode_bit;
                  error    <= 1'b1;
               end
            end
            default: begin
               pend <= pend;
            end
         endcase
      end
   end

   // Result-bank write forwarding, exactly one cycle behind ipf_valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_bank <= 2'd0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= accept;
         if (accept) begin
            wr_bank <= ipf_mode;
            wr_addr <= ipf_addr;
            wr_data <= ipf_data;
         end
      end
   end

endmodule
